// File: rtl/sweep_sequencer.sv
// sweep_sequencer: run controller for the triangle-wave sweep generator.
// Latches the sweep configuration, drives the generator on/hold inputs, and
// watches its direction output. It counts full periods, dwells at each
// turnaround, and stops after N periods or runs continuously.
// Optional build macro SWEEP_SEQ_RELOAD_EN: live config reload at period boundaries.
module sweep_sequencer #(
    parameter int CYCLE_W = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        cfg_minval,
    input  logic [15:0]        cfg_maxval,
    input  logic [31:0]        cfg_stepsize,
    input  logic [CYCLE_W-1:0] cfg_cycles,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_load,
    input  logic               sweep_state,
    output logic               sweep_on,
    output logic               sweep_hold,
    output logic [15:0]        minval,
    output logic [15:0]        maxval,
    output logic [31:0]        stepsize,
    output logic               busy,
    output logic               turn,
    output logic               done,
    output logic               err,
    output logic [CYCLE_W-1:0] period_count
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DWELL, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               arm_cnt;
    logic               sweep_state_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_q;
    logic [CYCLE_W-1:0] cycles_q, pc_inc;
    logic               cfg_valid, edge_any, edge_max;
    logic               do_start, period_hit, dwell_load;
    logic               reload_fire, reload_ok;
    logic               reload_err;

    assign cfg_valid = $signed(cfg_minval) < $signed(cfg_maxval);
    assign edge_any  = sweep_state != sweep_state_d;
    assign edge_max  = sweep_state & ~sweep_state_d;
    assign pc_inc    = (period_count == {CYCLE_W{1'b1}}) ? period_count : period_count + 1'b1;
    assign busy      = state != S_IDLE;

`ifdef SWEEP_SEQ_RELOAD_EN
    logic reload_pending;
    // A reload waits for the next max turnaround so each period runs on one config.
    assign reload_fire = period_hit & reload_pending;
    assign reload_ok   = reload_fire & cfg_valid;
    assign reload_err  = reload_fire & ~cfg_valid;

    // Remember a reload request made while the generator is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            reload_pending <= 1'b0;
        else if (state == S_IDLE || reload_fire)
            reload_pending <= 1'b0;
        else if (cfg_load && !abort && (state == S_RUN || state == S_DWELL))
            reload_pending <= 1'b1;
    end
`else
    logic unused_cfg_load;
    assign unused_cfg_load = cfg_load;
    assign reload_fire = 1'b0;
    assign reload_ok   = 1'b0;
    assign reload_err  = 1'b0;
`endif

    // Next-state and output decode; abort overrides every other event.
    always_comb begin
        state_nxt  = state;
        sweep_on   = 1'b0;
        sweep_hold = 1'b0;
        turn       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        do_start   = 1'b0;
        period_hit = 1'b0;
        dwell_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_valid) begin
                        do_start  = 1'b1;
                        state_nxt = S_ARM;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (arm_cnt) state_nxt = S_RUN;
            end
            S_RUN: begin
                sweep_on = 1'b1;
                if (edge_any) begin
                    turn = 1'b1;
                    if (edge_max) period_hit = 1'b1;
                    if (edge_max && cycles_q != '0 && pc_inc == cycles_q) begin
                        state_nxt = S_DONE;
                    end else if (dwell_q != '0) begin
                        state_nxt  = S_DWELL;
                        dwell_load = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                sweep_on   = 1'b1;
                sweep_hold = 1'b1;
                if (dwell_cnt == '0) state_nxt = S_RUN;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt  = S_IDLE;
            turn       = 1'b0;
            done       = 1'b0;
            period_hit = 1'b0;
            dwell_load = 1'b0;
        end
        if (reload_err) err = 1'b1;
    end

    // State register, ARM timer, dwell counter and direction history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            arm_cnt       <= 1'b0;
            dwell_cnt     <= '0;
            sweep_state_d <= 1'b1;
        end else begin
            state         <= state_nxt;
            arm_cnt       <= (state == S_ARM);
            sweep_state_d <= sweep_state;
            if (dwell_load)
                dwell_cnt <= dwell_q - 1'b1;
            else if (state == S_DWELL && dwell_cnt != '0)
                dwell_cnt <= dwell_cnt - 1'b1;
        end
    end

    // Active configuration and period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minval       <= '0;
            maxval       <= '0;
            stepsize     <= '0;
            dwell_q      <= '0;
            cycles_q     <= '0;
            period_count <= '0;
        end else begin
            if (do_start || reload_ok) begin
                minval   <= cfg_minval;
                maxval   <= cfg_maxval;
                stepsize <= cfg_stepsize;
                dwell_q  <= cfg_dwell;
            end
            if (do_start) begin
                cycles_q     <= cfg_cycles;
                period_count <= '0;
            end else if (period_hit) begin
                period_count <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed bench with a behavioural triangle generator.
module tb_sweep_sequencer;

    localparam int CW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, cfg_load = 1'b0;
    logic [15:0]   cfg_minval = '0, cfg_maxval = '0;
    logic [31:0]   cfg_stepsize = '0;
    logic [CW-1:0] cfg_cycles = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          sweep_state;
    logic          sweep_on, sweep_hold, busy, turn, done, err;
    logic [15:0]   minval, maxval;
    logic [31:0]   stepsize;
    logic [CW-1:0] period_count;

    int n_vec = 0;
    int n_err = 0;

    sweep_sequencer #(.CYCLE_W(CW), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_minval(cfg_minval), .cfg_maxval(cfg_maxval), .cfg_stepsize(cfg_stepsize),
        .cfg_cycles(cfg_cycles), .cfg_dwell(cfg_dwell), .cfg_load(cfg_load),
        .sweep_state(sweep_state), .sweep_on(sweep_on), .sweep_hold(sweep_hold),
        .minval(minval), .maxval(maxval), .stepsize(stepsize), .busy(busy),
        .turn(turn), .done(done), .err(err), .period_count(period_count)
    );

    always #5 clk = ~clk;

    // Triangle generator: resets to max going down while off, freezes on hold.
    longint acc;
    logic   gdir;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= 0;
            gdir <= 1'b1;
        end else if (!sweep_on) begin
            acc  <= longint'($signed(maxval)) * 65536;
            gdir <= 1'b1;
        end else if (!sweep_hold) begin
            if (gdir) begin
                if (acc - longint'(stepsize) <= longint'($signed(minval)) * 65536) begin
                    acc  <= longint'($signed(minval)) * 65536;
                    gdir <= 1'b0;
                end else acc <= acc - longint'(stepsize);
            end else begin
                if (acc + longint'(stepsize) >= longint'($signed(maxval)) * 65536) begin
                    acc  <= longint'($signed(maxval)) * 65536;
                    gdir <= 1'b1;
                end else acc <= acc + longint'(stepsize);
            end
        end
    end
    assign sweep_state = gdir;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] mn, input logic [15:0] mx, input logic [31:0] st,
                             input logic [CW-1:0] cy, input logic [DW-1:0] dw);
        @(negedge clk);
        cfg_minval = mn; cfg_maxval = mx; cfg_stepsize = st;
        cfg_cycles = cy; cfg_dwell = dw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        int turns, maxt, dones, tcyc, dcyc, hrun, hviol, htot, pc_seen;
        logic   prev_hold;
        longint prev_acc;

        // ---- reset state
        #12;
        chk("rst_on", sweep_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", period_count, 0);
        chk("rst_max", maxval, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- 3 periods, no dwell
        start_run(-16'sd100, 16'sd100, 32'h0001_0000, 3, 0);
        chk("arm0_busy", busy, 1);
        chk("arm0_on", sweep_on, 0);
        @(negedge clk);
        chk("arm1_on", sweep_on, 0);
        @(negedge clk);
        chk("run_on", sweep_on, 1);
        chk("run_min", $signed(minval), -100);
        chk("run_max", $signed(maxval), 100);
        chk("run_step", stepsize, 32'h0001_0000);
        turns = 0; maxt = 0; dones = 0; tcyc = -100; dcyc = 0;
        for (int c = 0; c < 3000 && dones == 0; c++) begin
            if (turn) begin
                turns++;
                if (sweep_state) begin
                    chk("pc_at_max_turn", period_count, maxt);
                    maxt++;
                    tcyc = c;
                end
            end
            if (done) begin
                dones++;
                dcyc = c;
                chk("pc_at_done", period_count, 3);
            end
            if (dones == 0) @(negedge clk);
        end
        chk("turns", turns, 6);
        chk("done_seen", dones, 1);
        chk("done_lat", dcyc - tcyc, 1);
        @(negedge clk);
        chk("post_on", sweep_on, 0);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_pc", period_count, 3);

        // ---- 3 periods, dwell 5
        start_run(-16'sd100, 16'sd100, 32'h0001_0000, 3, 5);
        turns = 0; dones = 0; hrun = 0; hviol = 0; htot = 0;
        prev_hold = 1'b0; prev_acc = 0;
        for (int c = 0; c < 4000 && dones == 0; c++) begin
            @(negedge clk);
            if (turn) turns++;
            if (done) dones++;
            if (prev_hold && acc != prev_acc) hviol++;
            if (sweep_hold) begin
                hrun++;
                htot++;
            end else if (prev_hold) begin
                chk("hold_len", hrun, 5);
                hrun = 0;
            end
            prev_hold = sweep_hold;
            prev_acc  = acc;
        end
        chk("dw_turns", turns, 6);
        chk("dw_done", dones, 1);
        chk("dw_hold_total", htot, 25);
        chk("dw_frozen", hviol, 0);

        // ---- rejected starts
        @(negedge clk);
        cfg_minval = 16'sd50; cfg_maxval = 16'sd50; start = 1'b1;
        #1 chk("err_eq", err, 1);
        @(negedge clk);
        start = 1'b0;
        #1 chk("err_eq_busy", busy, 0);
        chk("err_eq_clr", err, 0);
        @(negedge clk);
        cfg_minval = 16'sd200; cfg_maxval = -16'sd200; start = 1'b1;
        #1 chk("err_inv", err, 1);
        @(negedge clk);
        start = 1'b0;
        #1 chk("err_inv_busy", busy, 0);

        // ---- continuous run, then abort during dwell
        start_run(-16'sd100, 16'sd100, 32'h0008_0000, 0, 3);
        dones = 0;
        for (int c = 0; c < 3000 && period_count < 11; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("cont_periods", period_count, 11);
        chk("cont_no_done", dones, 0);
        for (int c = 0; c < 500 && !sweep_hold; c++) @(negedge clk);
        chk("cont_in_dwell", sweep_hold, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_on", sweep_on, 0);
        chk("abort_hold", sweep_hold, 0);
        chk("abort_done", done, 0);

        // ---- live reload request mid down-slope
        start_run(-16'sd100, 16'sd100, 32'h0001_0000, 0, 0);
        repeat (50) @(negedge clk);
        cfg_maxval = 16'sd300; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        repeat (5) @(negedge clk);
        chk("rl_hold_old", $signed(maxval), 100);
        pc_seen = 0;
        for (int c = 0; c < 1000 && pc_seen == 0; c++) begin
            @(negedge clk);
            if (turn && sweep_state) pc_seen = 1;
        end
        chk("rl_max_turn", pc_seen, 1);
        chk("rl_at_turn", $signed(maxval), 100);
        @(negedge clk);
`ifdef SWEEP_SEQ_RELOAD_EN
        chk("rl_after", $signed(maxval), 300);
`else
        chk("rl_after", $signed(maxval), 100);
`endif
        do_abort();

        // ---- asynchronous reset mid-run
        start_run(-16'sd100, 16'sd100, 32'h0008_0000, 0, 0);
        for (int c = 0; c < 500 && period_count == 0; c++) @(negedge clk);
        chk("mr_pc_pre", period_count, 1);
        rst = 1'b1;
        #1;
        chk("mr_on", sweep_on, 0);
        chk("mr_busy", busy, 0);
        chk("mr_pc", period_count, 0);
        chk("mr_max", maxval, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
